xyolo_databus_responder: RTL and testbench

- Memory-side responder for the versat databus protocol. Ext_addrgen-based stages are the initiators.
- Serves N_PORTS initiator ports through round-robin arbitration into one on-chip SRAM of DATABUS_W-bit words.
- Used as the external-memory model and local scratch target for the yolo read/write stages, in simulation and on FPGA without DDR.

---
 rtl/xyolo_databus_responder.sv | 150 +++++++++++++++
 tb/tb_xyolo_databus_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/xyolo_databus_responder.sv
// Round-robin databus responder: N_PORTS initiators share one byte-strobed SRAM.
// Optional range checking is compiled in with `define XYOLO_RESP_RANGE_CHECK_EN.
module xyolo_databus_responder #(
    parameter int N_PORTS    = 2,
    parameter int DATABUS_W  = 256,
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              databus_valid,
    input  logic [N_PORTS*ADDR_W-1:0]       databus_addr,
    input  logic [N_PORTS*DATABUS_W-1:0]    databus_wdata,
    input  logic [N_PORTS*DATABUS_W/8-1:0]  databus_wstrb,
    output logic [N_PORTS-1:0]              databus_ready,
    output logic [N_PORTS*DATABUS_W-1:0]    databus_rdata,
    output logic                            busy,
    output logic                            err
);

    localparam int SW    = DATABUS_W / 8;
    localparam int B     = $clog2(SW);
    localparam int GW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 1 << MEM_ADDR_W;

    // Handshake: an initiator holds valid/addr/wdata/wstrb until its ready bit
    // pulses for one cycle; the request is captured at grant, rdata is only
    // meaningful while ready is high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MEM_ADDR_W-1:0] widx_a  [N_PORTS];
    logic [DATABUS_W-1:0]  wdata_a [N_PORTS];
    logic [SW-1:0]         wstrb_a [N_PORTS];
    logic                  oor_a   [N_PORTS];

    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         grant_q;
    logic [MEM_ADDR_W-1:0] widx_q;
    logic [DATABUS_W-1:0]  wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  oor_q;
    logic [DATABUS_W-1:0]  rdata_q;

    logic                  pick_found;
    logic [GW-1:0]         pick_idx;
    logic [GW-1:0]         cand;

    logic [DATABUS_W-1:0]  mem [DEPTH];

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign widx_a[i]  = databus_addr[i*ADDR_W+B +: MEM_ADDR_W];
        assign wdata_a[i] = databus_wdata[i*DATABUS_W +: DATABUS_W];
        assign wstrb_a[i] = databus_wstrb[i*SW +: SW];
`ifdef XYOLO_RESP_RANGE_CHECK_EN
        assign oor_a[i] = |databus_addr[i*ADDR_W+MEM_ADDR_W+B +: ADDR_W-MEM_ADDR_W-B];
`else
        assign oor_a[i] = 1'b0;
`endif
    end

    // Byte-offset bits (and upper bits when unchecked) carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^databus_addr;

    // Scan from the port after the last winner so contention alternates.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = GW'((int'(last_grant) + i) % N_PORTS);
            if (!pick_found && databus_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(N_PORTS - 1);
            grant_q    <= '0;
            widx_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                grant_q <= pick_idx;
                widx_q  <= widx_a[pick_idx];
                wdata_q <= wdata_a[pick_idx];
                wstrb_q <= wstrb_a[pick_idx];
                oor_q   <= oor_a[pick_idx];
            end
            if (state == ACCESS) begin
                if (|wstrb_q || oor_q) rdata_q <= '0;
                else                   rdata_q <= mem[widx_q];
            end
            if (state == RESP) last_grant <= grant_q;
        end
    end

    // SRAM array is not reset; the write only happens on the ACCESS edge.
    always_ff @(posedge clk) begin
        if (state == ACCESS && |wstrb_q && !oor_q) begin
            for (int k = 0; k < SW; k++) begin
                if (wstrb_q[k]) mem[widx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
            end
        end
    end

`ifdef XYOLO_RESP_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           err_q <= 1'b0;
        else if (state == ACCESS && oor_q) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        databus_ready = '0;
        if (state == RESP) databus_ready[grant_q] = 1'b1;
    end

    assign databus_rdata = {N_PORTS{rdata_q}};
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_xyolo_databus_responder.sv
// Directed scoreboard bench for xyolo_databus_responder (2 ports, 256-bit words).
// Range-check expectations follow XYOLO_RESP_RANGE_CHECK_EN when defined.
module tb_xyolo_databus_responder;
  localparam int NP = 2;
  localparam int W  = 256;
  localparam int AW = 32;
  localparam int SW = W / 8;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   databus_valid;
  logic [NP*AW-1:0] databus_addr;
  logic [NP*W-1:0] databus_wdata;
  logic [NP*SW-1:0] databus_wstrb;
  logic [NP-1:0]   databus_ready;
  logic [NP*W-1:0] databus_rdata;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_port_q[$];

  xyolo_databus_responder #(
    .N_PORTS(NP), .DATABUS_W(W), .ADDR_W(AW), .MEM_ADDR_W(10)
  ) dut (
    .clk(clk), .rst(rst),
    .databus_valid(databus_valid), .databus_addr(databus_addr),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
    .databus_ready(databus_ready), .databus_rdata(databus_rdata),
    .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_port(input int p, input logic [AW-1:0] a, input logic [W-1:0] wd,
                            input logic [SW-1:0] ws);
    databus_addr[p*AW +: AW]  = a;
    databus_wdata[p*W +: W]   = wd;
    databus_wstrb[p*SW +: SW] = ws;
    databus_valid[p]          = 1'b1;
  endtask

  task automatic do_req(input int p, input logic [AW-1:0] a, input logic [W-1:0] wd,
                        input logic [SW-1:0] ws, input logic [W-1:0] exp_rd);
    int cycles;
    exp_q.push_back(exp_rd);
    exp_port_q.push_back(p);
    @(negedge clk);
    drive_port(p, a, wd, ws);
    cycles = 0;
    repeat (20) begin
      @(negedge clk);
      cycles++;
      if (databus_ready[p]) break;
    end
    databus_valid[p] = 1'b0;
    check("ready_latency", W'(cycles), W'(2));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && |databus_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=%b expected no response", databus_ready);
      end else begin
        logic [W-1:0] e;
        int ep;
        e  = exp_q.pop_front();
        ep = exp_port_q.pop_front();
        check("ready_port", W'(databus_ready), W'(1 << ep));
        check("rdata", databus_rdata[ep*W +: W], e);
      end
    end
  end

  initial begin
    logic [W-1:0] part_exp;
    logic [W-1:0] w0_exp;
    logic [W-1:0] hi_exp;
    int pulses;
    int last_cyc;
    rst = 1'b1;
    databus_valid = '0;
    databus_addr  = '0;
    databus_wdata = '0;
    databus_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", W'(databus_ready), '0);
    check("reset_rdata", databus_rdata[W-1:0], '0);
    check("reset_busy", W'(busy), '0);
    check("reset_err", W'(err), '0);
    repeat (20) @(negedge clk);

    // full write then read back
    do_req(0, 32'h40, {32{8'hA5}}, '1, '0);
    do_req(0, 32'h40, '0, '0, {32{8'hA5}});

    // partial write over a known word
    part_exp = {{28{8'h11}}, {4{8'hFF}}};
    do_req(0, 32'h60, {32{8'h11}}, '1, '0);
    do_req(1, 32'h60, {32{8'hFF}}, 32'h0000000F, '0);
    do_req(1, 32'h60, '0, '0, part_exp);

    // contention: last grant is port 1, so port 0 wins first
    do_req(0, 32'hA0, {32{8'h55}}, '1, '0);
    do_req(1, 32'hC0, {32{8'h66}}, '1, '0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32{8'h55}}); exp_port_q.push_back(0);
      exp_q.push_back({32{8'h66}}); exp_port_q.push_back(1);
    end
    @(negedge clk);
    drive_port(0, 32'hA0, '0, '0);
    drive_port(1, 32'hC0, '0, '0);
    pulses = 0;
    last_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (|databus_ready) begin
        if (pulses > 0) check("rr_spacing", W'(c - last_cyc), W'(3));
        last_cyc = c;
        pulses++;
        if (pulses == 6) break;
      end
    end
    databus_valid = '0;
    check("rr_pulses", W'(pulses), W'(6));

    // reset during ACCESS of a write: the write must not land
    do_req(0, 32'h80, {32{8'h22}}, '1, '0);
    @(negedge clk);
    drive_port(0, 32'h80, {32{8'h99}}, '1);
    @(negedge clk);
    check("access_busy", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("abort_ready", W'(databus_ready), '0);
    check("abort_busy", W'(busy), '0);
    check("abort_rdata", databus_rdata[W-1:0], '0);
    @(negedge clk);
    databus_valid = '0;
    rst = 1'b0;
    do_req(0, 32'h80, '0, '0, {32{8'h22}});

    // out-of-range address 0x8000 (bit 15 set)
`ifdef XYOLO_RESP_RANGE_CHECK_EN
    w0_exp = {32{8'h33}};
    hi_exp = '0;
`else
    w0_exp = {32{8'h44}};
    hi_exp = {32{8'h44}};
`endif
    do_req(0, 32'h0, {32{8'h33}}, '1, '0);
    check("err_before_range", W'(err), '0);
    do_req(1, 32'h8000, {32{8'h44}}, '1, '0);
`ifdef XYOLO_RESP_RANGE_CHECK_EN
    check("err_after_range", W'(err), W'(1));
`else
    check("err_after_range", W'(err), '0);
`endif
    do_req(0, 32'h0, '0, '0, w0_exp);
    do_req(1, 32'h8000, '0, '0, hi_exp);

    repeat (10) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("queue_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
